// File: rtl/synch_fifo_pkg.sv
// synch_fifo_pkg: shared types, default sizes and width helpers for synch_fifo_thresh.
//   err_e      : error codes for logging (ERR_NONE, ERR_OVF, ERR_UDF)
//   clog2_safe : $clog2 clamped to a minimum of 1 bit
//   ptr_w      : pointer width for a given depth
//   cnt_w      : occupancy-count width for a given depth (must hold DEPTH itself)
package synch_fifo_pkg;
    typedef enum logic [1:0] {ERR_NONE, ERR_OVF, ERR_UDF} err_e;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 4;
    function automatic int clog2_safe(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
    function automatic int ptr_w(input int depth);
        return clog2_safe(depth);
    endfunction
    function automatic int cnt_w(input int depth);
        return clog2_safe(depth + 1);
    endfunction
endpackage

// File: rtl/synch_fifo_thresh_if.sv
// synch_fifo_thresh_if: producer/consumer bus of synch_fifo_thresh.
//   master : drives chip_select, write_enable, read_enable, flush, clear_errors, data_in
//   slave  : drives data_out, fifo_full, fifo_empty, almost_full, almost_empty, count,
//            overflow, underflow
interface synch_fifo_thresh_if
    import synch_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
);
    logic                      chip_select;
    logic                      write_enable;
    logic                      read_enable;
    logic                      flush;
    logic                      clear_errors;
    logic [DATA_W-1:0]         data_in;
    logic [DATA_W-1:0]         data_out;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      almost_full;
    logic                      almost_empty;
    logic [cnt_w(DEPTH)-1:0]   count;
    logic                      overflow;
    logic                      underflow;

    modport master (
        output chip_select, write_enable, read_enable, flush, clear_errors, data_in,
        input  data_out, fifo_full, fifo_empty, almost_full, almost_empty, count,
               overflow, underflow
    );

    modport slave (
        input  chip_select, write_enable, read_enable, flush, clear_errors, data_in,
        output data_out, fifo_full, fifo_empty, almost_full, almost_empty, count,
               overflow, underflow
    );
endinterface

// File: rtl/synch_fifo_ptr.sv
// synch_fifo_ptr: pointer counter that wraps DEPTH-1 -> 0 (works for any DEPTH).
//   clk, reset : clock, asynchronous active-high reset
//   i_inc      : advance pointer
//   i_clr      : synchronous clear to 0 (wins over i_inc)
//   o_ptr      : current pointer
module synch_fifo_ptr #(
    parameter int DEPTH = 4,
    parameter int W     = 2
)(
    input  logic         clk,
    input  logic         reset,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_ptr
);
    localparam logic [W-1:0] LAST = W'(DEPTH - 1);

    logic [W-1:0] r_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_ptr <= '0;
        else if (i_clr)
            r_ptr <= '0;
        else if (i_inc)
            r_ptr <= (r_ptr == LAST) ? '0 : r_ptr + 1'b1;
    end

    assign o_ptr = r_ptr;
endmodule

// File: rtl/synch_fifo_thresh.sv
// synch_fifo_thresh: single-clock FIFO, any depth, with occupancy count, almost-full/empty
// thresholds, synchronous flush and sticky overflow/underflow flags.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : synch_fifo_thresh_if.slave (requests in; data, count and flags out)
// Optional macro SYNCH_FIFO_FWFT_EN: first-word-fall-through data_out (zero read latency);
// undefined gives a registered data_out one cycle after each accepted read.
module synch_fifo_thresh
    import synch_fifo_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
)(
    input logic                 clk,
    input logic                 reset,
    synch_fifo_thresh_if.slave  bus
);
    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);

    if (DEPTH < 2 || AF_LEVEL > DEPTH) begin : g_bad_param
        $error("synch_fifo_thresh: invalid parameters DEPTH=%0d AF_LEVEL=%0d", DEPTH, AF_LEVEL);
    end

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  w_wr_ptr, w_rd_ptr;
    logic [CNT_W-1:0]  r_count, w_cnt_nxt;
    logic              r_full, r_empty, r_af, r_ae, r_ovf, r_udf;
    logic              w_wr_req, w_rd_req, w_rd_acc, w_wr_acc, w_do_wr, w_do_rd;

    assign w_wr_req = bus.chip_select & bus.write_enable;
    assign w_rd_req = bus.chip_select & bus.read_enable;
    assign w_rd_acc = w_rd_req & ~r_empty;
    // A read in the same cycle frees a slot, so a write on full still goes in.
    assign w_wr_acc = w_wr_req & (~r_full | w_rd_acc);
    // Flush drops any same-cycle transfer.
    assign w_do_wr  = w_wr_acc & ~bus.flush;
    assign w_do_rd  = w_rd_acc & ~bus.flush;

    always_comb
        w_cnt_nxt = bus.flush                ? '0 :
                    (w_wr_acc & ~w_rd_acc)   ? r_count + 1'b1 :
                    (w_rd_acc & ~w_wr_acc)   ? r_count - 1'b1 : r_count;

    synch_fifo_ptr #(.DEPTH(DEPTH), .W(PTR_W)) u_wr_ptr (
        .clk(clk), .reset(reset), .i_inc(w_do_wr), .i_clr(bus.flush), .o_ptr(w_wr_ptr)
    );

    synch_fifo_ptr #(.DEPTH(DEPTH), .W(PTR_W)) u_rd_ptr (
        .clk(clk), .reset(reset), .i_inc(w_do_rd), .i_clr(bus.flush), .o_ptr(w_rd_ptr)
    );

    always_ff @(posedge clk)
        if (w_do_wr) r_mem[w_wr_ptr] <= bus.data_in;

    // Flags come from the next-state count so they line up with count after the edge.
    // Error flags: a new error beats clear_errors; flush clears without setting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_af    <= (AF_LEVEL <= 0);
            r_ae    <= (AE_LEVEL >= 0);
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            r_count <= w_cnt_nxt;
            r_full  <= int'(w_cnt_nxt) == DEPTH;
            r_empty <= w_cnt_nxt == '0;
            r_af    <= int'(w_cnt_nxt) >= AF_LEVEL;
            r_ae    <= int'(w_cnt_nxt) <= AE_LEVEL;
            r_ovf   <= ~bus.flush & ((w_wr_req & ~w_wr_acc) | (r_ovf & ~bus.clear_errors));
            r_udf   <= ~bus.flush & ((w_rd_req & r_empty) | (r_udf & ~bus.clear_errors));
        end
    end

`ifdef SYNCH_FIFO_FWFT_EN
    assign bus.data_out = r_empty ? '0 : r_mem[w_rd_ptr];
`else
    logic [DATA_W-1:0] r_dout;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_dout <= '0;
        else if (w_do_rd)
            r_dout <= r_mem[w_rd_ptr];
    end

    assign bus.data_out = r_dout;
`endif

    assign bus.fifo_full    = r_full;
    assign bus.fifo_empty   = r_empty;
    assign bus.almost_full  = r_af;
    assign bus.almost_empty = r_ae;
    assign bus.count        = r_count;
    assign bus.overflow     = r_ovf;
    assign bus.underflow    = r_udf;
endmodule

// File: tb/tb_synch_fifo_thresh.sv
// tb_synch_fifo_thresh: drives a DEPTH=4/32-bit and a DEPTH=5/8-bit FIFO with identical
// stimulus and compares every output against a queue-style reference model.
module tb_synch_fifo_thresh;
    import synch_fifo_pkg::*;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_err;
    int   nstep;

    synch_fifo_thresh_if #(.DATA_W(32), .DEPTH(4)) if4 ();
    synch_fifo_thresh_if #(.DATA_W(8),  .DEPTH(5)) if5 ();

    synch_fifo_thresh #(.DATA_W(32), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1)) u4 (
        .clk(clk), .reset(reset), .bus(if4)
    );
    synch_fifo_thresh #(.DATA_W(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(2)) u5 (
        .clk(clk), .reset(reset), .bus(if5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: contents held as an ordered list, front entry at index 0.
    int          msz   [2];
    logic [31:0] mbuf  [2][8];
    logic        movf  [2];
    logic        mudf  [2];
    logic [31:0] mdout [2];

    function automatic int dep(input int k);
        return (k == 0) ? 4 : 5;
    endfunction
    function automatic int afl(input int k);
        return (k == 0) ? 3 : 4;
    endfunction
    function automatic int ael(input int k);
        return (k == 0) ? 1 : 2;
    endfunction
    function automatic logic [31:0] mask(input int k);
        return (k == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    endfunction

    task automatic mreset();
        for (int k = 0; k < 2; k++) begin
            msz[k]   = 0;
            movf[k]  = 1'b0;
            mudf[k]  = 1'b0;
            mdout[k] = '0;
        end
    endtask

    task automatic mstep(input int k, input logic cs, we, re, fl, ce, input logic [31:0] d);
        logic wr_req, rd_req, rd_acc, wr_acc;
        wr_req = cs & we;
        rd_req = cs & re;
        if (fl) begin
            msz[k]  = 0;
            movf[k] = 1'b0;
            mudf[k] = 1'b0;
        end else begin
            rd_acc = rd_req && (msz[k] > 0);
            wr_acc = wr_req && ((msz[k] < dep(k)) || rd_acc);
            if (rd_acc) begin
                mdout[k] = mbuf[k][0];
                for (int i = 0; i < 7; i++) mbuf[k][i] = mbuf[k][i+1];
                msz[k]--;
            end
            if (wr_acc) begin
                mbuf[k][msz[k]] = d & mask(k);
                msz[k]++;
            end
            movf[k] = (wr_req && !wr_acc) || (movf[k] && !ce);
            mudf[k] = (rd_req && !rd_acc) || (mudf[k] && !ce);
        end
    endtask

    task automatic cmp(input int k, input string nm, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL step%0d dut%0d %s observed %0h expected %0h", nstep, k, nm, obs, exp);
        end
    endtask

    task automatic check(input int k);
        logic [31:0] od, oc, ed;
        logic        f, e, af, ae, ov, ud;
        if (k == 0) begin
            od = if4.data_out;      oc = 32'(if4.count);
            f  = if4.fifo_full;     e  = if4.fifo_empty;
            af = if4.almost_full;   ae = if4.almost_empty;
            ov = if4.overflow;      ud = if4.underflow;
        end else begin
            od = 32'(if5.data_out); oc = 32'(if5.count);
            f  = if5.fifo_full;     e  = if5.fifo_empty;
            af = if5.almost_full;   ae = if5.almost_empty;
            ov = if5.overflow;      ud = if5.underflow;
        end
`ifdef SYNCH_FIFO_FWFT_EN
        ed = (msz[k] != 0) ? mbuf[k][0] : 32'h0;
`else
        ed = mdout[k];
`endif
        cmp(k, "data_out",     od, ed);
        cmp(k, "count",        oc, 32'(msz[k]));
        cmp(k, "fifo_full",    32'(f),  32'(msz[k] == dep(k)));
        cmp(k, "fifo_empty",   32'(e),  32'(msz[k] == 0));
        cmp(k, "almost_full",  32'(af), 32'(msz[k] >= afl(k)));
        cmp(k, "almost_empty", 32'(ae), 32'(msz[k] <= ael(k)));
        cmp(k, "overflow",     32'(ov), 32'(movf[k]));
        cmp(k, "underflow",    32'(ud), 32'(mudf[k]));
    endtask

    task automatic drive(input logic cs, we, re, fl, ce, input logic [31:0] d);
        if4.chip_select = cs; if4.write_enable = we; if4.read_enable = re;
        if4.flush = fl; if4.clear_errors = ce; if4.data_in = d;
        if5.chip_select = cs; if5.write_enable = we; if5.read_enable = re;
        if5.flush = fl; if5.clear_errors = ce; if5.data_in = d[7:0];
    endtask

    task automatic step(input logic cs, we, re, fl, ce, input logic [31:0] d);
        @(negedge clk);
        drive(cs, we, re, fl, ce, d);
        mstep(0, cs, we, re, fl, ce, d);
        mstep(1, cs, we, re, fl, ce, d);
        @(posedge clk);
        #1;
        nstep++;
        check(0);
        check(1);
    endtask

    task automatic wr(input logic [31:0] d);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, d);
    endtask
    task automatic rd();
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    endtask

    // Reset asserted between clock edges; outputs must clear before the next edge.
    task automatic async_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        mreset();
        #1;
        nstep++;
        check(0);
        check(1);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic cs, we, re, fl, ce;
        n_chk = 0;
        n_err = 0;
        nstep = 0;
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        mreset();
        #1;
        check(0);
        check(1);
        @(negedge clk);
        reset = 1'b0;

        // Basic order and latency: 1, 10, 100 in, then out.
        wr(32'd1); wr(32'd10); wr(32'd100);
        cmp(0, "lit_count3", 32'(if4.count), 32'd3);
        cmp(0, "lit_af_at3", 32'(if4.almost_full), 32'd1);
        rd();
`ifndef SYNCH_FIFO_FWFT_EN
        cmp(0, "lit_rd1", if4.data_out, 32'd1);
`endif
        rd();
`ifndef SYNCH_FIFO_FWFT_EN
        cmp(0, "lit_rd10", if4.data_out, 32'd10);
`endif
        rd();
`ifndef SYNCH_FIFO_FWFT_EN
        cmp(0, "lit_rd100", if4.data_out, 32'd100);
`endif
        cmp(0, "lit_empty", 32'(if4.fifo_empty), 32'd1);

        // Underflow, then simultaneous read+write on empty, then clear.
        rd();
        cmp(0, "lit_udf", 32'(if4.underflow), 32'd1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd55);
        cmp(0, "lit_cnt_rw_empty", 32'(if4.count), 32'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        rd();

        // Non-power-of-2 wrap on the 5-deep FIFO.
        for (int i = 0; i < 5; i++) wr(32'(i));
        rd(); rd();
        wr(32'd5); wr(32'd6);
        cmp(1, "lit_full5", 32'(if5.fifo_full), 32'd1);
        for (int i = 0; i < 5; i++) rd();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);

        // Full handling: rejected write, read+write on full, set beats clear.
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) wr($urandom);
        wr(32'd16);
        cmp(0, "lit_ovf", 32'(if4.overflow), 32'd1);
        cmp(0, "lit_cnt_full", 32'(if4.count), 32'd4);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd16);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'd17);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        cmp(0, "lit_ovf_clr", 32'(if4.overflow), 32'd0);

        // Flush with a same-cycle write; chip_select gating.
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        wr(32'd7); wr(32'd8); wr(32'd9);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd77);
        cmp(0, "lit_flush_empty", 32'(if4.fifo_empty), 32'd1);
        wr(32'd3);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd99);

        // Random traffic, alternating write-heavy and read-heavy phases.
        for (int i = 0; i < 400; i++) begin
            if (i == 230) async_reset();
            cs = $urandom_range(0, 7) != 0;
            we = ((i % 80) < 40) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            re = ((i % 80) < 40) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            fl = $urandom_range(0, 47) == 0;
            ce = $urandom_range(0, 15) == 0;
            step(cs, we, re, fl, ce, $urandom);
        end

        // Reset in the middle of a burst.
        wr(32'd21); wr(32'd22); rd();
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd23);
        async_reset();
        wr(32'd24); rd();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
